// File: rtl/sys_intr_ctrl.sv
// System register file and vectored, nestable interrupt controller.
// Edge-latched requests, mask, fixed lowest-index priority and a hardware return stack.
module sys_intr_ctrl #(
   parameter int N_IRQ          = 4,
   parameter int NEST_DEPTH     = 4,
   parameter int VEC_SHIFT      = 0,
   parameter int DATA_BIT_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              isSpecial,
   input  logic [4:0]                        opcode,
   input  logic [DATA_BIT_WIDTH-1:0]         nxtPc,
   input  logic [N_IRQ-1:0]                  irq,
   input  logic [3:0]                        rdindex,
   input  logic [3:0]                        wrtindex,
   input  logic [DATA_BIT_WIDTH-1:0]         dataIn,
   output logic [DATA_BIT_WIDTH-1:0]         pcAddrOut,
   output logic                              pcIntrSel,
   output logic [DATA_BIT_WIDTH-1:0]         spRegOut,
   output logic                              ieOut,
   output logic [16:0]                       ihaOut,
   output logic [N_IRQ-1:0]                  intAck,
   output logic [$clog2(NEST_DEPTH+1)-1:0]   nestLevel
);

   localparam int DW    = $clog2(NEST_DEPTH + 1);
   localparam int DBW   = DATA_BIT_WIDTH;
   // Stack arrays are sized to the full depth-counter range so any counter value is a legal index.
   localparam int SLOTS = 1 << DW;
   localparam logic [DW-1:0] DEPTH_MAX = DW'(NEST_DEPTH);

   localparam logic [3:0] OP_RETI = 4'h1;
   localparam logic [3:0] OP_WSR  = 4'h3;

   localparam logic [3:0] R_PCS = 4'd0;
   localparam logic [3:0] R_IHA = 4'd1;
   localparam logic [3:0] R_IRA = 4'd2;
   localparam logic [3:0] R_IDN = 4'd3;
   localparam logic [3:0] R_IMR = 4'd4;
   localparam logic [3:0] R_IPR = 4'd5;

   logic [N_IRQ-1:0] irq_q, irq_d;
   logic             ie_q, ie_d;
   logic [DBW-1:0]   iha_q, iha_d;
   logic [N_IRQ-1:0] imr_q, imr_d;
   logic [N_IRQ-1:0] ipr_q, ipr_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic [DBW-1:0]   ret_q [SLOTS];
   logic [DBW-1:0]   ret_d [SLOTS];
   logic [3:0]       id_q  [SLOTS];
   logic [3:0]       id_d  [SLOTS];
   logic             sie_q [SLOTS];
   logic             sie_d [SLOTS];

   logic             is_reti, is_wsr, wsr_en, take, has_frame;
   logic [N_IRQ-1:0] rise, eligible, ack;
   logic [3:0]       sel_id;
   logic [DW-1:0]    top;
   logic [DBW-1:0]   vec_off, pcs_rd;
   logic             unused_op;

   assign unused_op = opcode[4];

   always_comb begin
      is_reti   = isSpecial && (opcode[3:0] == OP_RETI);
      is_wsr    = isSpecial && (opcode[3:0] == OP_WSR);
      rise      = irq & ~irq_q;
      eligible  = ipr_q & imr_q;
      has_frame = (depth_q != '0);
      top       = depth_q - DW'(1);
      sel_id    = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) sel_id = 4'(i);
      end
      take   = ie_q && (|eligible) && !is_reti && (depth_q < DEPTH_MAX);
      wsr_en = is_wsr && !take;
      ack    = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         ack[i] = take && (sel_id == 4'(i));
      end
      vec_off = (VEC_SHIFT == 0) ? '0 : (DBW'(sel_id) << VEC_SHIFT);
   end

   always_comb begin
      irq_d   = irq;
      ie_d    = ie_q;
      iha_d   = iha_q;
      imr_d   = imr_q;
      ipr_d   = ipr_q;
      depth_d = depth_q;
      ret_d   = ret_q;
      id_d    = id_q;
      sie_d   = sie_q;
      if (take) begin
         ret_d[depth_q] = nxtPc;
         id_d[depth_q]  = sel_id;
         sie_d[depth_q] = ie_q;
         ie_d           = 1'b0;
         ipr_d          = ipr_q & ~ack;
         depth_d        = depth_q + DW'(1);
      end else if (is_reti && has_frame) begin
         ie_d    = sie_q[top];
         depth_d = top;
      end else if (wsr_en) begin
         case (wrtindex)
            R_PCS: ie_d  = dataIn[0];
            R_IHA: iha_d = dataIn;
            R_IRA: if (has_frame) ret_d[top] = dataIn;
            R_IDN: if (has_frame) id_d[top] = dataIn[3:0];
            R_IMR: imr_d = dataIn[N_IRQ-1:0];
            R_IPR: ipr_d = ipr_q & ~dataIn[N_IRQ-1:0];
            default: ;
         endcase
      end
      // A new edge always wins over any clear in the same cycle.
      ipr_d = ipr_d | rise;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q   <= '0;
         ie_q    <= 1'b1;
         iha_q   <= '0;
         imr_q   <= '1;
         ipr_q   <= '0;
         depth_q <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            ret_q[i] <= '0;
            id_q[i]  <= '0;
            sie_q[i] <= 1'b0;
         end
      end else begin
         irq_q   <= irq_d;
         ie_q    <= ie_d;
         iha_q   <= iha_d;
         imr_q   <= imr_d;
         ipr_q   <= ipr_d;
         depth_q <= depth_d;
         ret_q   <= ret_d;
         id_q    <= id_d;
         sie_q   <= sie_d;
      end
   end

   always_comb begin
      pcs_rd        = '0;
      pcs_rd[0]     = ie_q;
      pcs_rd[1]     = has_frame && sie_q[top];
      pcs_rd[15:8]  = 8'(depth_q);
      case (rdindex)
         R_PCS:   spRegOut = pcs_rd;
         R_IHA:   spRegOut = iha_q;
         R_IRA:   spRegOut = has_frame ? ret_q[top] : '0;
         R_IDN:   spRegOut = has_frame ? DBW'(id_q[top]) : '0;
         R_IMR:   spRegOut = DBW'(imr_q);
         R_IPR:   spRegOut = DBW'(ipr_q);
         default: spRegOut = '0;
      endcase
   end

   always_comb begin
      if (is_reti) pcAddrOut = has_frame ? ret_q[top] : '0;
      else         pcAddrOut = iha_q + vec_off;
      pcIntrSel = take || is_reti;
      intAck    = ack;
      ieOut     = ie_q;
      ihaOut    = iha_q[16:0];
      nestLevel = depth_q;
   end

endmodule

// File: tb/tb_sys_intr_ctrl.sv
// Directed plus randomized bench for sys_intr_ctrl, checked against a queue-based
// behavioural model of the interrupt rules.
module tb_sys_intr_ctrl;
   localparam int VS = 4;
   localparam int ND = 4;
   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_RETI = 5'h01;
   localparam logic [4:0] OP_WSR  = 5'h03;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        isSpecial;
   logic [4:0]  opcode;
   logic [31:0] nxtPc;
   logic [3:0]  irq;
   logic [3:0]  rdindex, wrtindex;
   logic [31:0] dataIn;
   logic [31:0] pcAddrOut;
   logic        pcIntrSel;
   logic [31:0] spRegOut;
   logic        ieOut;
   logic [16:0] ihaOut;
   logic [3:0]  intAck;
   logic [2:0]  nestLevel;

   sys_intr_ctrl #(.N_IRQ(4), .NEST_DEPTH(ND), .VEC_SHIFT(VS), .DATA_BIT_WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .isSpecial(isSpecial), .opcode(opcode), .nxtPc(nxtPc),
      .irq(irq), .rdindex(rdindex), .wrtindex(wrtindex), .dataIn(dataIn),
      .pcAddrOut(pcAddrOut), .pcIntrSel(pcIntrSel), .spRegOut(spRegOut), .ieOut(ieOut),
      .ihaOut(ihaOut), .intAck(intAck), .nestLevel(nestLevel)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] ret;
      logic [3:0]  id;
      logic        ie;
   } ent_t;

   logic        m_ie;
   logic [31:0] m_iha;
   logic [3:0]  m_imr, m_ipr, m_prev;
   ent_t        stk[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_ie = 1'b1; m_iha = '0; m_imr = 4'hF; m_ipr = '0; m_prev = '0;
      stk.delete();
   endtask

   task automatic m_decide(output bit take, output int id, output bit reti, output bit wsr);
      reti = isSpecial && (opcode[3:0] == 4'h1);
      wsr  = isSpecial && (opcode[3:0] == 4'h3);
      id = -1;
      for (int i = 0; i < 4; i++) if (id < 0 && m_ipr[i] && m_imr[i]) id = i;
      take = m_ie && (id >= 0) && !reti && (stk.size() < ND);
   endtask

   task automatic m_check();
      bit take, reti, wsr;
      int id, d;
      logic [31:0] exp_rd, exp_pc;
      ent_t t;
      m_decide(take, id, reti, wsr);
      d = stk.size();
      t = '{ret: '0, id: '0, ie: 1'b0};
      if (d > 0) t = stk[d-1];
      case (rdindex)
         4'd0: exp_rd = (d << 8) | (t.ie ? 32'd2 : 32'd0) | {31'd0, m_ie};
         4'd1: exp_rd = m_iha;
         4'd2: exp_rd = t.ret;
         4'd3: exp_rd = {28'd0, t.id};
         4'd4: exp_rd = {28'd0, m_imr};
         4'd5: exp_rd = {28'd0, m_ipr};
         default: exp_rd = '0;
      endcase
      chk("pcIntrSel", {31'd0, pcIntrSel}, {31'd0, take | reti});
      if (take || reti) begin
         if (reti) exp_pc = t.ret;
         else exp_pc = m_iha + ((VS != 0) ? (32'(id) << VS) : 32'd0);
         chk("pcAddrOut", pcAddrOut, exp_pc);
      end
      chk("intAck", {28'd0, intAck}, take ? (32'd1 << id) : 32'd0);
      chk("spRegOut", spRegOut, exp_rd);
      chk("ieOut", {31'd0, ieOut}, {31'd0, m_ie});
      chk("ihaOut", {15'd0, ihaOut}, {15'd0, m_iha[16:0]});
      chk("nestLevel", {29'd0, nestLevel}, 32'(d));
   endtask

   task automatic m_update();
      bit take, reti, wsr;
      int id;
      ent_t e;
      logic [3:0] rise;
      m_decide(take, id, reti, wsr);
      rise = irq & ~m_prev;
      if (take) begin
         e.ret = nxtPc; e.id = 4'(id); e.ie = m_ie;
         stk.push_back(e);
         m_ie = 1'b0;
         m_ipr[id] = 1'b0;
      end else if (reti && stk.size() > 0) begin
         e = stk.pop_back();
         m_ie = e.ie;
      end else if (wsr) begin
         case (wrtindex)
            4'd0: m_ie = dataIn[0];
            4'd1: m_iha = dataIn;
            4'd2: if (stk.size() > 0) begin e = stk.pop_back(); e.ret = dataIn; stk.push_back(e); end
            4'd3: if (stk.size() > 0) begin e = stk.pop_back(); e.id = dataIn[3:0]; stk.push_back(e); end
            4'd4: m_imr = dataIn[3:0];
            4'd5: m_ipr = m_ipr & ~dataIn[3:0];
            default: ;
         endcase
      end
      m_ipr = m_ipr | rise;
      m_prev = irq;
   endtask

   task automatic drive(input bit sp, input logic [4:0] op, input logic [3:0] wi, input logic [31:0] din,
                        input logic [3:0] ri, input logic [3:0] iv, input logic [31:0] nxt);
      isSpecial = sp; opcode = op; wrtindex = wi; dataIn = din;
      rdindex = ri; irq = iv; nxtPc = nxt;
      #1;
      m_check();
   endtask

   task automatic tick();
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; isSpecial = 0; opcode = '0; nxtPc = '0; irq = '0;
      rdindex = '0; wrtindex = '0; dataIn = '0;
      m_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ie", {31'd0, ieOut}, 32'd1);
      chk("rst_sel", {31'd0, pcIntrSel}, 32'd0);
      chk("rst_ack", {28'd0, intAck}, 32'd0);
      chk("rst_nest", {29'd0, nestLevel}, 32'd0);
      chk("rst_iha", {15'd0, ihaOut}, 32'd0);
      reset_n = 1'b1;

      // Single request, basic entry and return.
      drive(1, OP_WSR, 4'd1, 32'h100, 4'd1, 4'b0000, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0100, 0);
      chk("tp1_early", {31'd0, pcIntrSel}, 32'd0);
      tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0100, 32'h40);
      chk("tp1_sel", {31'd0, pcIntrSel}, 32'd1);
      chk("tp1_addr", pcAddrOut, 32'h120);
      chk("tp1_ack", {28'd0, intAck}, 32'h4);
      tick();
      drive(0, OP_NOP, 0, 0, 4'd2, 4'b0000, 0);
      chk("tp1_ira", spRegOut, 32'h40);
      drive(0, OP_NOP, 0, 0, 4'd3, 4'b0000, 0);
      chk("tp1_idn", spRegOut, 32'h2);
      chk("tp1_ie", {31'd0, ieOut}, 32'd0);
      chk("tp1_nest", {29'd0, nestLevel}, 32'd1);
      tick();
      drive(1, OP_RETI, 0, 0, 4'd0, 4'b0000, 0);
      chk("tp1_reti", pcAddrOut, 32'h40);
      tick();

      // Simultaneous requests: lowest index first, vectored.
      drive(1, OP_WSR, 4'd1, 32'h200, 4'd1, 4'b0000, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b1010, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b1010, 32'h80);
      chk("tp2_addr", pcAddrOut, 32'h210);
      chk("tp2_ack", {28'd0, intAck}, 32'h2);
      tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0000, 0);
      chk("tp2_ipr3", spRegOut, 32'h8);
      tick();
      drive(1, OP_RETI, 0, 0, 4'd0, 4'b0000, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd3, 4'b0000, 32'h84); tick();
      drive(1, OP_RETI, 0, 0, 4'd0, 4'b0000, 0); tick();

      // Nest to full depth, fifth request waits for a free level.
      for (int k = 0; k < 4; k++) begin
         drive(0, OP_NOP, 0, 0, 4'd0, 4'(1 << k), 0); tick();
         drive(0, OP_NOP, 0, 0, 4'd0, 4'b0000, 32'h1000 + 32'(4 * k));
         chk("nest_take", {31'd0, pcIntrSel}, 32'd1);
         tick();
         drive(1, OP_WSR, 4'd0, 32'h1, 4'd0, 4'b0000, 0); tick();
      end
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0001, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0000, 32'h2000);
      chk("full_sel", {31'd0, pcIntrSel}, 32'd0);
      chk("full_nest", {29'd0, nestLevel}, 32'd4);
      chk("full_ipr", spRegOut, 32'h1);
      tick();
      drive(1, OP_RETI, 0, 0, 4'd0, 4'b0000, 0);
      chk("full_reti", pcAddrOut, 32'h100C);
      tick();
      drive(0, OP_NOP, 0, 0, 4'd0, 4'b0000, 32'h2000);
      chk("full_take", {28'd0, intAck}, 32'h1);
      chk("full_taddr", pcAddrOut, 32'h200);
      tick();
      repeat (4) begin drive(1, OP_RETI, 0, 0, 4'd0, 4'b0000, 0); tick(); end

      // Masked request stays pending until unmasked.
      drive(1, OP_WSR, 4'd4, 32'hE, 4'd4, 4'b0000, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0001, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0000, 0);
      chk("mask_hold", {31'd0, pcIntrSel}, 32'd0);
      tick();
      drive(1, OP_WSR, 4'd4, 32'hF, 4'd5, 4'b0000, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd4, 4'b0000, 32'h3000);
      chk("mask_take", {28'd0, intAck}, 32'h1);
      tick();
      drive(1, OP_RETI, 0, 0, 4'd0, 4'b0000, 0); tick();

      // RETI with an empty stack.
      drive(1, OP_RETI, 0, 0, 4'd0, 4'b0000, 0);
      chk("reti0_sel", {31'd0, pcIntrSel}, 32'd1);
      chk("reti0_addr", pcAddrOut, 32'h0);
      tick();
      drive(0, OP_NOP, 0, 0, 4'd0, 4'b0000, 0);
      chk("reti0_ie", {31'd0, ieOut}, 32'd1);

      // Set beats write-1-to-clear; then reset in the middle of nesting.
      drive(1, OP_WSR, 4'd5, 32'h2, 4'd5, 4'b0010, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd5, 4'b0010, 32'h500);
      chk("w1c_set", spRegOut, 32'h2);
      tick();
      drive(1, OP_WSR, 4'd0, 32'h1, 4'd0, 4'b0000, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd0, 4'b0001, 0); tick();
      drive(0, OP_NOP, 0, 0, 4'd0, 4'b0000, 32'h600); tick();
      drive(0, OP_NOP, 0, 0, 4'd0, 4'b0000, 0);
      chk("pre_rst_nest", {29'd0, nestLevel}, 32'd2);
      reset_n = 1'b0;
      #1;
      chk("arst_nest", {29'd0, nestLevel}, 32'd0);
      chk("arst_ie", {31'd0, ieOut}, 32'd1);
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [4:0] op;
         logic [3:0] wi;
         logic [31:0] din;
         bit sp;
         r = $urandom_range(0, 9);
         sp = 1'b0; op = OP_NOP; wi = '0; din = $urandom;
         if (r <= 1) begin sp = 1; op = OP_WSR; wi = 4'd0; din = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0; end
         else if (r == 2) begin sp = 1; op = OP_RETI; end
         else if (r == 3) begin sp = 1; op = OP_WSR; wi = 4'($urandom_range(0, 15)); end
         else if (r == 4) begin sp = ($urandom_range(0, 1) == 1); op = 5'($urandom); wi = 4'($urandom); end
         op[4] = 1'($urandom);
         drive(sp, op, wi, din, 4'($urandom_range(0, 15)), 4'($urandom), $urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sys_intr_ctrl.md
# sys_intr_ctrl

Parametrised system register file and interrupt controller for the pipelined core. It replaces the single-line, single-level scheme with N_IRQ edge-latched request lines, a mask register, fixed priority, optional vectoring and a hardware nesting stack of depth NEST_DEPTH. It sits beside the general register file in decode/execute and drives the PC mux on interrupt entry and RETI. Special instructions are RSR (read), WSR (write, opcode[3:0]=4'h3) and RETI (opcode[3:0]=4'h1), each qualified by isSpecial.

## Interface
- N_IRQ, 4: number of interrupt request lines, 1..16.
- NEST_DEPTH, 4: maximum nested interrupt levels, ≥1.
- VEC_SHIFT, 0: 0 sends every handler to IHA; >0 sends handler to IHA + (id << VEC_SHIFT).
- DATA_BIT_WIDTH, 32: system register width.
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- isSpecial  in  1  current instruction is a system instruction.
- opcode  in  5  secondary opcode; [3:0] decoded.
- nxtPc  in  32  return address saved on interrupt entry.
- irq  in  N_IRQ  request lines, rising-edge sensitive.
- rdindex, wrtindex  in  4 each  system register indices.
- dataIn  in  32  WSR data.
- pcAddrOut  out  32  redirect target.
- pcIntrSel  out  1  PC mux selects pcAddrOut this cycle.
- spRegOut  out  32  RSR read data, combinational from rdindex.
- ieOut  out  1  current interrupt enable.
- ihaOut  out  17  IHA[16:0].
- intAck  out  N_IRQ  one-hot pulse, the cycle an interrupt is taken.
- nestLevel  out  clog2(NEST_DEPTH+1)  current stack depth.

## Operation
- Register map: 0 PCS (bit0 IE R/W; bit1 saved IE of top entry, read-only; bits[15:8] depth, read-only); 1 IHA R/W; 2 IRA (top entry return address); 3 IDN (top entry id, zero-extended); 4 IMR mask R/W; 5 IPR pending (write-1-to-clear). Indices 6–15 read 0; writes to them are ignored.
- Edge detect: irq_q registered each cycle; rise = irq & ~irq_q sets the IPR bit. If set and clear hit the same bit in one cycle, set wins.
- Eligible = IPR & IMR. Chosen id is the lowest-index eligible bit.
- Take condition: IE=1, eligible≠0, RETI not active this cycle, and nestLevel<NEST_DEPTH.
- On take: push {nxtPc, id, IE}, IE←0, clear IPR[id], assert intAck[id], depth+1. A WSR in the same cycle is dropped.
- RETI with depth>0: IE←saved IE of the top entry, pop, depth−1. pcAddrOut = top IRA.
- RETI with depth 0: state unchanged, pcIntrSel=1, pcAddrOut=0.
- WSR to IRA/IDN overwrites the top entry. At depth 0 it is ignored.
- WSR to PCS writes bit0 only.
- WSR and RETI are mutually exclusive by opcode.
- pcIntrSel = take | RETI.
- pcAddrOut = RETI ? top IRA : IHA + (VEC_SHIFT ? id<<VEC_SHIFT : 0).
- Full stack: requests stay pending and are taken after a RETI frees a level, provided IE=1.

## Timing
- Reset values: IE=1, IHA=0, IMR=all ones, IPR=0, depth=0, irq_q=0, all stack entries 0. Resulting outputs: ieOut=1, pcIntrSel=0, intAck=0, nestLevel=0, ihaOut=0.
- Reset mid-handler discards the whole stack immediately; it is asynchronous.
- irq rising before edge k sets IPR at edge k. Take is combinationally visible (pcIntrSel, intAck) during cycle k→k+1 and committed at edge k+1. Two-cycle latency from request to redirect.
- Held-high irq causes one pending event only. It must fall and rise again to re-request.
- RSR is zero-latency. A WSR at edge k is visible on spRegOut from cycle k+1.
- Taken handler clears IE at commit, so back-to-back takes need software to re-enable IE (WSR PCS) first.

## Test plan
- Reset, then pulse irq[2] with IHA=0x100, VEC_SHIFT=0, nxtPc=0x40 -> pcIntrSel=1, pcAddrOut=0x100, intAck=4'b0100; after commit IRA=0x40, IDN=2, IE=0, nestLevel=1.
- irq[1] and irq[3] rise in the same cycle, VEC_SHIFT=4, IHA=0x200 -> id 1 is taken first, pcAddrOut=0x210; IPR[3] remains set.
- Nesting to depth 4 (handler sets IE=1 each level) with a fifth request -> no take, IPR bit held, nestLevel=4. One RETI -> pcAddrOut = level-4 return address, then the fifth request is taken.
- IMR=4'b1110 and irq[0] rises -> pending but never taken. WSR IMR=4'b1111 -> taken next cycle.
- RETI at depth 0 -> pcIntrSel=1, pcAddrOut=0, IE and stack unchanged.
- WSR IPR=4'b0010 in the same cycle irq[1] rises -> IPR[1] stays 1. Assert reset_n=0 at depth 2 -> nestLevel=0 and IE=1 immediately.
